// File: rtl/rnd_lfsr_feeder.sv
// Randomness feeder for masked gadgets: seeded 64-bit LFSR, RND_W steps per delivered word.
// Optional RND_FEEDER_CNT_EN adds a saturating 32-bit handshake counter on port rnd_cnt.
module rnd_lfsr_feeder #(
  parameter int d        = 2,
  parameter int RND_W    = d * (d - 1),
  parameter int WARM_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      seed,
  input  logic             seed_valid,
  output logic             seed_ready,
  output logic [RND_W-1:0] rnd_out,
  output logic             rnd_valid,
  input  logic             rnd_ready
`ifdef RND_FEEDER_CNT_EN
  ,
  output logic [31:0]      rnd_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [63:0] s_r;
  logic [63:0] s_nxt_s;
  logic [7:0]  warm_cnt_r;
  logic [7:0]  warm_cnt_nxt_s;
  logic        seed_ready_r;
  logic        seed_ready_nxt_s;
  logic        rnd_valid_r;
  logic        rnd_valid_nxt_s;
  logic        seed_acc_s;

  // RND_W single steps of x^64+x^63+x^61+x^60+1, unrolled into one cycle
  function automatic logic [63:0] lfsr_adv(input logic [63:0] s_in);
    logic [63:0] s_v;
    s_v = s_in;
    for (int i = 0; i < RND_W; i++) begin
      s_v = {s_v[62:0], s_v[63] ^ s_v[62] ^ s_v[60] ^ s_v[59]};
    end
    return s_v;
  endfunction

  assign seed_acc_s = seed_valid & seed_ready_r;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; a seed in RUN wins over a consume
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (seed_acc_s) begin
          state_nxt_s = ST_WARMUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WARMUP: begin
        if (warm_cnt_r <= 8'd1) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_WARMUP;
        end
      end
      ST_RUN: begin
        if (seed_acc_s) begin
          state_nxt_s = ST_WARMUP;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs, computed from the next state so they can be registered
  always_comb begin
    seed_ready_nxt_s = 1'b0;
    rnd_valid_nxt_s  = 1'b0;
    case (state_nxt_s)
      ST_IDLE: begin
        seed_ready_nxt_s = 1'b1;
        rnd_valid_nxt_s  = 1'b0;
      end
      ST_WARMUP: begin
        seed_ready_nxt_s = 1'b0;
        rnd_valid_nxt_s  = 1'b0;
      end
      ST_RUN: begin
        seed_ready_nxt_s = 1'b1;
        rnd_valid_nxt_s  = 1'b1;
      end
      default: begin
        seed_ready_nxt_s = 1'b0;
        rnd_valid_nxt_s  = 1'b0;
      end
    endcase
  end

  // LFSR state and warm-up counter; an all-zero seed would lock the LFSR, so it loads as 1
  always_comb begin
    s_nxt_s        = s_r;
    warm_cnt_nxt_s = warm_cnt_r;
    if (seed_acc_s) begin
      s_nxt_s        = (seed == 64'd0) ? 64'd1 : seed;
      warm_cnt_nxt_s = 8'(WARM_CYC);
    end else if (state_r == ST_WARMUP) begin
      s_nxt_s        = lfsr_adv(s_r);
      warm_cnt_nxt_s = warm_cnt_r - 8'd1;
    end else if ((state_r == ST_RUN) && rnd_ready) begin
      s_nxt_s        = lfsr_adv(s_r);
      warm_cnt_nxt_s = warm_cnt_r;
    end else begin
      s_nxt_s        = s_r;
      warm_cnt_nxt_s = warm_cnt_r;
    end
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_r          <= 64'd0;
      warm_cnt_r   <= 8'd0;
      seed_ready_r <= 1'b0;
      rnd_valid_r  <= 1'b0;
    end else begin
      s_r          <= s_nxt_s;
      warm_cnt_r   <= warm_cnt_nxt_s;
      seed_ready_r <= seed_ready_nxt_s;
      rnd_valid_r  <= rnd_valid_nxt_s;
    end
  end

  assign seed_ready = seed_ready_r;
  assign rnd_valid  = rnd_valid_r;
  assign rnd_out    = s_r[RND_W-1:0];

`ifdef RND_FEEDER_CNT_EN
  logic [31:0] rnd_cnt_r;

  // Completed handshakes, saturating; survives reseeding
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rnd_cnt_r <= 32'd0;
    end else if (rnd_valid_r && rnd_ready && (rnd_cnt_r != 32'hFFFF_FFFF)) begin
      rnd_cnt_r <= rnd_cnt_r + 32'd1;
    end else begin
      rnd_cnt_r <= rnd_cnt_r;
    end
  end

  assign rnd_cnt = rnd_cnt_r;
`endif

endmodule

// File: tb/tb_rnd_lfsr_feeder.sv
// Bench for rnd_lfsr_feeder: two instances (RND_W=2/WARM_CYC=1 and RND_W=6/WARM_CYC=5)
// share stimulus and are checked against a step-count reference model and a vector table.
module tb_rnd_lfsr_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        seed_valid;
  logic [63:0] seed;
  logic        rnd_ready;
  logic        sready_a, valid_a, sready_b, valid_b;
  logic [1:0]  out_a;
  logic [5:0]  out_b;
`ifdef RND_FEEDER_CNT_EN
  logic [31:0] cnt_a, cnt_b;
`endif

  rnd_lfsr_feeder #(.d(2), .WARM_CYC(1)) u_a (
    .clk(clk), .rst_n(rst_n), .seed(seed), .seed_valid(seed_valid),
    .seed_ready(sready_a), .rnd_out(out_a), .rnd_valid(valid_a), .rnd_ready(rnd_ready)
`ifdef RND_FEEDER_CNT_EN
    , .rnd_cnt(cnt_a)
`endif
  );

  rnd_lfsr_feeder #(.d(3), .WARM_CYC(5)) u_b (
    .clk(clk), .rst_n(rst_n), .seed(seed), .seed_valid(seed_valid),
    .seed_ready(sready_b), .rnd_out(out_b), .rnd_valid(valid_b), .rnd_ready(rnd_ready)
`ifdef RND_FEEDER_CNT_EN
    , .rnd_cnt(cnt_b)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: LFSR value, pending warm-up advances, expected flags, handshake count
  int          m_w[2]    = '{2, 6};
  int          m_wcyc[2] = '{1, 5};
  logic [63:0] m_s[2]    = '{64'd0, 64'd0};
  int          m_warm[2] = '{0, 0};
  logic        m_valid[2] = '{1'b0, 1'b0};
  logic        m_sready[2] = '{1'b0, 1'b0};
  logic [63:0] m_cnt[2]  = '{64'd0, 64'd0};

  function automatic logic [63:0] ref_steps(input logic [63:0] s, input int n);
    logic [63:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
    return v;
  endfunction

  task automatic model_edge(input int k, input logic r, input logic sv,
                            input logic [63:0] sd, input logic rr);
    logic acc, hs;
    if (!r) begin
      m_s[k] = 64'd0; m_warm[k] = 0; m_valid[k] = 1'b0; m_sready[k] = 1'b0; m_cnt[k] = 64'd0;
    end else begin
      acc = sv && m_sready[k];
      hs  = m_valid[k] && rr;
      if (hs && m_cnt[k] != 64'hFFFF_FFFF) m_cnt[k] = m_cnt[k] + 64'd1;
      if (acc) begin
        m_s[k] = (sd == 64'd0) ? 64'd1 : sd;
        m_warm[k] = m_wcyc[k]; m_valid[k] = 1'b0; m_sready[k] = 1'b0;
      end else if (m_warm[k] > 0) begin
        m_s[k] = ref_steps(m_s[k], m_w[k]);
        m_warm[k] = m_warm[k] - 1;
        if (m_warm[k] == 0) begin m_valid[k] = 1'b1; m_sready[k] = 1'b1; end
      end else if (m_valid[k] && rr) begin
        m_s[k] = ref_steps(m_s[k], m_w[k]);
      end else if (!m_valid[k]) begin
        m_sready[k] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a.valid",  {63'd0, valid_a},  {63'd0, m_valid[0]});
    chk("a.sready", {63'd0, sready_a}, {63'd0, m_sready[0]});
    chk("a.out",    {62'd0, out_a},    m_s[0] & 64'h3);
    chk("b.valid",  {63'd0, valid_b},  {63'd0, m_valid[1]});
    chk("b.sready", {63'd0, sready_b}, {63'd0, m_sready[1]});
    chk("b.out",    {58'd0, out_b},    m_s[1] & 64'h3F);
`ifdef RND_FEEDER_CNT_EN
    chk("a.cnt", {32'd0, cnt_a}, m_cnt[0]);
    chk("b.cnt", {32'd0, cnt_b}, m_cnt[1]);
`endif
  endtask

  task automatic step(input logic r, input logic sv, input logic [63:0] sd, input logic rr);
    rst_n = r; seed_valid = sv; seed = sd; rnd_ready = rr;
    @(posedge clk);
    model_edge(0, r, sv, sd, rr);
    model_edge(1, r, sv, sd, rr);
    #1;
    check_all();
  endtask

  typedef struct {
    logic        sv;
    logic [63:0] sd;
    logic        rr;
    logic        e_valid;
    logic        e_sready;
    logic [1:0]  e_out;
  } vec_t;

  vec_t tbl[11];
  int   nz;
  int   lowb;
  logic [63:0] rs;

  initial begin
    // Hand-derived values for instance a (RND_W=2, WARM_CYC=1)
    tbl[0]  = '{1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[1]  = '{1'b0, 64'h0,                   1'b0, 1'b1, 1'b1, 2'b10};
    tbl[2]  = '{1'b0, 64'h0,                   1'b1, 1'b1, 1'b1, 2'b00};
    tbl[3]  = '{1'b0, 64'h0,                   1'b0, 1'b1, 1'b1, 2'b00};
    tbl[4]  = '{1'b1, 64'h0,                   1'b0, 1'b0, 1'b0, 2'b01};
    tbl[5]  = '{1'b0, 64'h0,                   1'b0, 1'b1, 1'b1, 2'b00};
    tbl[6]  = '{1'b0, 64'h0,                   1'b1, 1'b1, 1'b1, 2'b00};
    tbl[7]  = '{1'b0, 64'h0,                   1'b1, 1'b1, 1'b1, 2'b00};
    tbl[8]  = '{1'b1, 64'hA000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 2'b00};
    tbl[9]  = '{1'b0, 64'h0,                   1'b0, 1'b1, 1'b1, 2'b11};
    tbl[10] = '{1'b0, 64'h0,                   1'b1, 1'b1, 1'b1, 2'b10};

    rst_n = 1'b0; seed_valid = 1'b0; seed = 64'd0; rnd_ready = 1'b0;

    // Reset, then 20 idle cycles without a seed
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 64'd0, 1'b0);
    chk("reset.sready_a", {63'd0, sready_a}, 64'd0);
    chk("reset.out_a", {62'd0, out_a}, 64'd0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 64'd0, 1'b0);
    chk("idle.sready_a", {63'd0, sready_a}, 64'd1);
    chk("idle.valid_b", {63'd0, valid_b}, 64'd0);

    // Vector table
    for (int i = 0; i < 11; i++) begin
      step(1'b1, tbl[i].sv, tbl[i].sd, tbl[i].rr);
      chk($sformatf("tbl%0d.valid", i),  {63'd0, valid_a},  {63'd0, tbl[i].e_valid});
      chk($sformatf("tbl%0d.sready", i), {63'd0, sready_a}, {63'd0, tbl[i].e_sready});
      chk($sformatf("tbl%0d.out", i),    {62'd0, out_a},    {62'd0, tbl[i].e_out});
    end

    // Zero seed must not lock up over 1000 consumes
    step(1'b1, 1'b1, 64'd0, 1'b0);
    nz = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, 1'b0, 64'd0, 1'b1);
      if (out_a != 2'b00) nz++;
    end
    chk("seed0.nonzero_words_seen", {63'd0, (nz > 100)}, 64'd1);

    // Backpressure: hold for 10 cycles, then 5 consumes
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 64'd0, 1'b1);

    // Reseed in RUN together with a consume; a competing seed during warm-up is refused
    step(1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1);
    lowb = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i < 3), 64'h0F0F_0000_FFFF_0001, 1'b0);
      if (!sready_b) lowb++;
    end
    chk("reseed.b_warmup_cycles", lowb, 64'd4);
    rs = ref_steps(64'h1234_5678_9ABC_DEF0, 5 * 6);
    chk("reseed.b_first_word", {58'd0, out_b}, rs & 64'h3F);

    // Reset in the middle of warm-up, then the same seed again from clean state
    step(1'b1, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, 1'b0);
    step(1'b1, 1'b0, 64'd0, 1'b0);
    step(1'b1, 1'b0, 64'd0, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0);
    chk("midreset.out_b", {58'd0, out_b}, 64'd0);
    step(1'b1, 1'b0, 64'd0, 1'b0);
    step(1'b1, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 64'd0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom},
           $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rnd_lfsr_feeder.md
# rnd_lfsr_feeder

- Supplies fresh randomness words to masked gadgets, e.g. HPC3 AND gadgets, which consume `d*(d-1)` random bits per cycle.
- Holds a seeded 64-bit maximal-length LFSR and unrolls it `RND_W` steps per delivered word.
- Exposes the word through a valid/ready handshake so gadget pipelines only advance the stream when a word is consumed.
- Sits between the seed source (TRNG/host) and the gadget `rnd` ports; one instance per randomness bus.

## Interface
- `d`, 2: number of shares of the fed gadgets.
- `RND_W`, `d*(d-1)`: bits per delivered word; legal range 1..64.
- `WARM_CYC`, 16: warm-up cycles after seeding; legal range 1..255.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `seed`  in  64  seed value.
- `seed_valid`  in  1  seed offered.
- `seed_ready`  out  1  seed can be accepted.
- `rnd_out`  out  `RND_W`  random word; equals `state[RND_W-1:0]`.
- `rnd_valid`  out  1  `rnd_out` is usable.
- `rnd_ready`  in  1  consumer takes `rnd_out` this cycle.

## Operation
- State register `s[63:0]`; one LFSR step is fb = s[63]^s[62]^s[60]^s[59]; s ← {s[62:0], fb}. Polynomial: x^64+x^63+x^61+x^60+1.
- "Advance": the state is replaced by the result of `RND_W` consecutive steps in one cycle. Because `RND_W` ≤ 64, every bit of `rnd_out` is fresh after an advance.
- Seed acceptance: a seed is accepted when `seed_valid && seed_ready`. An all-zero seed is loaded as 64'h1, since the LFSR would otherwise lock up.
- FSM states:
  - IDLE (unseeded): `seed_ready`=1, `rnd_valid`=0. Seed accept → load seed, warm-up counter ← `WARM_CYC`, go to WARMUP.
  - WARMUP: `seed_ready`=0, `rnd_valid`=0. Each cycle: advance and decrement the counter. When the counter reaches 1 (the last advance), go to RUN.
  - RUN: `seed_ready`=1, `rnd_valid`=1.
    - `rnd_ready`=1: advance.
    - `rnd_ready`=0: hold the state unchanged, so an unconsumed word is never discarded.
    - Seed accept: load seed, go to WARMUP. This has priority over advance.
- Simultaneous seed accept and consume in RUN:
  - The consumer's handshake completes with the current word.
  - The next state is the loaded seed, not an advance.
- Reset: while `rst_n`=0 at an edge → IDLE, s=0, counter=0, `rnd_valid`=0, `seed_ready`=0 during the reset cycle. This applies at any point, including mid-warm-up.

## Timing
- Reset values: `rnd_valid`=0, `rnd_out`=0, `seed_ready`=0 while `rst_n` is asserted, and 1 from the first cycle after release (IDLE).
- A seed accepted at edge k sets `rnd_valid`=1 after edge k+`WARM_CYC`. The first word has undergone exactly `WARM_CYC` advances.
- In RUN, sustained throughput is one word per cycle with zero bubbles. `rnd_out` changes only on the edge after a handshake.
- `rnd_valid` and `rnd_out` are register-driven, with no combinational path from `rnd_ready` or `seed_valid` to any output.
- `seed_ready` depends only on FSM state.

## Configuration
- `RND_FEEDER_CNT_EN`, when defined:
  - Adds output port `rnd_cnt` (32 bits): count of completed `rnd_valid && rnd_ready` handshakes.
  - The count saturates at 0xFFFF_FFFF.
  - It is cleared by reset and is not cleared by reseeding.
- Not defined: the port and counter do not exist. All other behaviour is identical.

## Test plan
- Reset release, no seed: for 20 cycles `rnd_valid`=0, `rnd_out`=0, and `seed_ready`=1 from the first post-reset cycle.
- `RND_W`=2, `WARM_CYC`=1, seed 64'h8000_0000_0000_0000 accepted at edge k → after edge k+1, `rnd_valid`=1 and `rnd_out`=2'b10 (s=2). Consume once → `rnd_out`=2'b00 (s=8).
- Seed 0 with `WARM_CYC`=1, `RND_W`=2 → behaves as seed 1: the first word is 2'b00 (s=4), and the stream never sticks at all-zero over 1000 consumes.
- Backpressure: RUN with `rnd_ready`=0 for 10 cycles → `rnd_out` is constant. Then 5 consumes → exactly 5 distinct advances matching a reference model.
- Reseed in RUN with `rnd_ready`=1 at the same edge → handshake counted (`rnd_cnt`+1 with `RND_FEEDER_CNT_EN`), then WARMUP for `WARM_CYC` cycles with `seed_ready`=0. The first word matches the model of the new seed.
- `rst_n`=0 in the middle of WARMUP → IDLE next cycle, s=0. A later seed gives the same word sequence as from a clean reset.
